// File: rtl/cmos_dvp_tx.sv
// rtl/cmos_dvp_tx.sv - DVP camera source emitting RGB565 frames with registered vsync/href/data.
// Pattern macro: CMOS_DVP_TX_STRIPE_EN selects eight vertical colour bars instead of the pixel counter.
module cmos_dvp_tx #(
  parameter int H_PIXEL     = 800,
  parameter int V_PIXEL     = 480,
  parameter int H_BLANK     = 64,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 2,
  parameter int V_FRONT     = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       gen_en,
  output logic       cam_vsync,
  output logic       cam_href,
  output logic [7:0] cam_data,
  output logic       frame_done,
  output logic       busy
);

  localparam int POS_TOTAL  = 2 * H_PIXEL + H_BLANK;
  localparam int LINE_TOTAL = VSYNC_LINES + V_BACK + V_PIXEL + V_FRONT;
  localparam int POS_W      = $clog2(POS_TOTAL);
  localparam int LINE_W     = $clog2(LINE_TOTAL);

  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(POS_TOTAL - 1);
  localparam logic [POS_W-1:0]  POS_ACT   = POS_W'(2 * H_PIXEL);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINE_TOTAL - 1);
  localparam logic [LINE_W-1:0] VS_LAST   = LINE_W'(VSYNC_LINES - 1);
  localparam logic [LINE_W-1:0] ACT_FIRST = LINE_W'(VSYNC_LINES + V_BACK);
  localparam logic [LINE_W-1:0] ACT_LAST  = LINE_W'(VSYNC_LINES + V_BACK + V_PIXEL - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FRAME = 1'b1;

  logic [0:0]        state;
  logic [POS_W-1:0]  pos;
  logic [LINE_W-1:0] line;

  logic              last_pos;
  logic              last_line;
  logic              in_frame;
  logic              frame_end;
  logic              start;
  logic              run_next;
  logic [POS_W-1:0]  nxt_pos;
  logic [LINE_W-1:0] nxt_line;
  logic              nxt_vsync;
  logic              nxt_href;
  logic              nxt_done;
  logic [7:0]        nxt_data;
  logic [15:0]       pix_val;

  // Counters track the position being presented; outputs are registered from the next position.
  always_comb begin
    last_pos  = (pos == POS_LAST);
    last_line = (line == LINE_LAST);
    in_frame  = (state == S_FRAME);
    frame_end = in_frame && last_pos && last_line;
    start     = gen_en && (!in_frame || frame_end);
    run_next  = start || (in_frame && !frame_end);

    nxt_pos  = pos;
    nxt_line = line;
    if (start) begin
      nxt_pos  = '0;
      nxt_line = '0;
    end else if (last_pos) begin
      nxt_pos  = '0;
      nxt_line = line + 1'b1;
    end else begin
      nxt_pos  = pos + 1'b1;
    end

    nxt_vsync = run_next && (nxt_line <= VS_LAST);
    nxt_href  = run_next && (nxt_line >= ACT_FIRST) && (nxt_line <= ACT_LAST)
                && (nxt_pos < POS_ACT);
    nxt_done  = run_next && (nxt_pos == POS_LAST) && (nxt_line == LINE_LAST);
  end

`ifdef CMOS_DVP_TX_STRIPE_EN
  localparam logic [POS_W-1:0] BAR_W = POS_W'(H_PIXEL / 8);

  logic [POS_W-1:0] pix_idx;
  logic [2:0]       bar_sel;

  always_comb begin
    pix_idx = nxt_pos >> 1;
    bar_sel = 3'(pix_idx / BAR_W);
    case (bar_sel)
      3'd0:    pix_val = 16'hFFFF;
      3'd1:    pix_val = 16'hFFE0;
      3'd2:    pix_val = 16'h07FF;
      3'd3:    pix_val = 16'h07E0;
      3'd4:    pix_val = 16'hF81F;
      3'd5:    pix_val = 16'hF800;
      3'd6:    pix_val = 16'h001F;
      default: pix_val = 16'h0000;
    endcase
  end
`else
  logic [15:0] pix_cnt;

  // The counter advances once the low byte of an active pixel has been presented.
  always_comb begin
    if (start) begin
      pix_val = 16'h0000;
    end else if (cam_href && pos[0]) begin
      pix_val = pix_cnt + 16'h0001;
    end else begin
      pix_val = pix_cnt;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_cnt <= 16'h0000;
    end else begin
      pix_cnt <= run_next ? pix_val : 16'h0000;
    end
  end
`endif

  always_comb begin
    nxt_data = 8'h00;
    if (nxt_href) begin
      nxt_data = nxt_pos[0] ? pix_val[7:0] : pix_val[15:8];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      pos        <= '0;
      line       <= '0;
      cam_vsync  <= 1'b0;
      cam_href   <= 1'b0;
      cam_data   <= 8'h00;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= run_next ? S_FRAME : S_IDLE;
      pos        <= run_next ? nxt_pos : '0;
      line       <= run_next ? nxt_line : '0;
      cam_vsync  <= nxt_vsync;
      cam_href   <= nxt_href;
      cam_data   <= nxt_data;
      frame_done <= nxt_done;
      busy       <= run_next;
    end
  end

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// tb/tb_cmos_dvp_tx.sv - scoreboard bench for cmos_dvp_tx on a 5-line x 20-clock frame.
module tb_cmos_dvp_tx;

  localparam int HP = 8;
  localparam int VP = 2;
  localparam int HB = 4;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int LPOS = 2 * HP + HB;
  localparam int NLINE = VS + VB + VP + VF;
  localparam int FCLK = LPOS * NLINE;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       gen_en;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_data;
  logic       frame_done;
  logic       busy;

  int tests_run;
  int tests_failed;
  int cyc;
  int href_cnt;
  int done_cnt;
  bit mon_en;

  // {vsync, href, data, frame_done, busy}
  logic [11:0] exp_q[$];

  cmos_dvp_tx #(
    .H_PIXEL(HP), .V_PIXEL(VP), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .gen_en(gen_en),
    .cam_vsync(cam_vsync),
    .cam_href(cam_href),
    .cam_data(cam_data),
    .frame_done(frame_done),
    .busy(busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [15:0] model_pixel(input int line, input int pos);
    logic [15:0] bars [8];
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
`ifdef CMOS_DVP_TX_STRIPE_EN
    model_pixel = bars[(pos / 2) / (HP / 8)];
`else
    model_pixel = 16'((line - VS - VB) * HP + pos / 2);
`endif
  endfunction

  task automatic push_frame();
    int line;
    int pos;
    logic act;
    logic [15:0] pix;
    logic [7:0] d;
    for (int c = 0; c < FCLK; c++) begin
      line = c / LPOS;
      pos  = c % LPOS;
      act  = (line >= VS + VB) && (line < VS + VB + VP) && (pos < 2 * HP);
      pix  = model_pixel(line, pos);
      d    = act ? ((pos % 2 == 0) ? pix[15:8] : pix[7:0]) : 8'h00;
      exp_q.push_back({(line < VS) ? 1'b1 : 1'b0, act, d, (c == FCLK - 1) ? 1'b1 : 1'b0, 1'b1});
    end
  endtask

  // Scoreboard: every clock the DUT outputs are compared with the next queued entry, or idle.
  always @(posedge sys_clk) begin
    logic [11:0] exp_v;
    logic [11:0] got_v;
    #1;
    if (mon_en) begin
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 12'h000;
      got_v = {cam_vsync, cam_href, cam_data, frame_done, busy};
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL scoreboard cyc=%0d got vs/href/data/done/busy=%b/%b/%h/%b/%b exp=%b/%b/%h/%b/%b",
                 cyc, got_v[11], got_v[10], got_v[9:2], got_v[1], got_v[0],
                 exp_v[11], exp_v[10], exp_v[9:2], exp_v[1], exp_v[0]);
      end
      if (cam_href) href_cnt++;
      if (frame_done) done_cnt++;
      cyc++;
    end
  end

  task automatic test_reset();
    sys_rst_n = 1'b0;
    gen_en    = 1'b0;
    #1;
    tests_run++;
    if ({cam_vsync, cam_href, cam_data, frame_done, busy} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_values got=%h exp=000", {cam_vsync, cam_href, cam_data, frame_done, busy});
    end
    mon_en = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_single_frame();
    href_cnt = 0;
    done_cnt = 0;
    gen_en = 1'b1;
    push_frame();
    @(negedge sys_clk);
    gen_en = 1'b0;
    repeat (FCLK - 1 + 4) @(negedge sys_clk);
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL single_done_count got=%0d exp=1", done_cnt);
    end
    tests_run++;
    if (href_cnt !== 2 * HP * VP) begin
      tests_failed++;
      $display("FAIL single_href_clocks got=%0d exp=%0d", href_cnt, 2 * HP * VP);
    end
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL single_queue_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    done_cnt = 0;
    gen_en = 1'b1;
    repeat (3) push_frame();
    repeat (2 * FCLK + 50) @(negedge sys_clk);
    gen_en = 1'b0;
    repeat (FCLK - 50 + 3) @(negedge sys_clk);
    tests_run++;
    if (done_cnt !== 3) begin
      tests_failed++;
      $display("FAIL b2b_done_count got=%0d exp=3", done_cnt);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_gen_drop();
    done_cnt = 0;
    gen_en = 1'b1;
    push_frame();
    @(negedge sys_clk);
    repeat (40) @(negedge sys_clk);
    gen_en = 1'b0;
    repeat (FCLK - 41 + 3) @(negedge sys_clk);
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL drop_done_count got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    gen_en = 1'b1;
    push_frame();
    @(negedge sys_clk);
    gen_en = 1'b0;
    repeat (3 * LPOS + 5) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    tests_run++;
    if ({cam_vsync, cam_href, cam_data, frame_done, busy} !== 12'h000) begin
      tests_failed++;
      $display("FAIL async_reset got=%h exp=000", {cam_vsync, cam_href, cam_data, frame_done, busy});
    end
    exp_q.delete();
    gen_en = 1'b1;
    repeat (2) @(negedge sys_clk);
    done_cnt = 0;
    push_frame();
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    gen_en = 1'b0;
    repeat (FCLK - 1 + 3) @(negedge sys_clk);
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL post_reset_done_count got=%0d exp=1", done_cnt);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    href_cnt     = 0;
    done_cnt     = 0;
    mon_en       = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gen_drop();
    test_reset_mid_frame();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
